rx_frame_ctrl: RTL and testbench
================================

RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter: BUFFER_DEPTH, default 16, byte capacity of the receive buffer (power of two, 4..64).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  13.56 MHz recovered carrier clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rx_enable  in  1  1 = accept frame_decode outputs; 0 = ignore them (PICC transmitting).
- fd_soc, fd_eoc  in  1  start/end of comms pulses from frame_decode.
- fd_data  in  8  received byte, LSB first.
- fd_data_bits  in  3  valid bits in fd_data; 0 = 8.
- fd_data_valid  in  1  fd_data valid pulse.
- fd_sequence_error, fd_parity_error  in  1  error pulses.
- out_data  out  8  head-of-buffer byte.
- out_data_bits  out  3  valid bits of out_data; 0 = 8.
- out_valid  out  1  buffer non-empty.
- out_ready  in  1  consumer pop.
- frame_done  out  1  one-cycle end-of-frame status strobe.
- frame_len  out  7  bytes written this frame, including a partial byte; saturates at BUFFER_DEPTH.
- frame_partial  out  1  last byte was partial (data_bits != 0).
- crc_ok  out  1  CRC_A residue check passed.
- frame_error  out  1  sequence, parity or overflow error in this frame.

Function
REQ-003 The FSM SHALL have states IDLE, RX, DONE; reset state IDLE.
REQ-004 IDLE->RX on fd_soc && rx_enable: flush buffer, clear frame_len, crc_ok, frame_partial and frame_error, load the CRC register with CRC_A_INIT.
REQ-005 RX->DONE on fd_eoc; DONE->IDLE unconditionally after one cycle; frame_done SHALL be 1 exactly in the DONE cycle.
REQ-006 In RX, each fd_data_valid SHALL push {fd_data, fd_data_bits} into the buffer; out_valid rises the next cycle if the buffer was empty.
REQ-007 Full bytes SHALL update the CRC register (CRC_A, poly 0x8408 reflected, one byte per cycle); partial bytes SHALL NOT.
REQ-008 crc_ok SHALL be 1 in DONE only if no partial byte, frame_len >= 3, no frame_error, and CRC register == 16'h0000.
REQ-009 Coincident fd_data_valid and fd_eoc (partial final byte) SHALL store the byte, set frame_partial, and enter DONE; frame_done follows one cycle later.
REQ-010 A push when the buffer is full SHALL drop the byte and set frame_error and overflow; frame_len still increments until it saturates.
REQ-011 fd_sequence_error or fd_parity_error in RX SHALL set frame_error; subsequent fd_data_valid are still stored.
REQ-012 Pop: out_valid && out_ready SHALL remove the head in the same edge; simultaneous push and pop SHALL leave the count unchanged.
REQ-013 The buffer SHALL be readable in any state; the consumer may drain during RX.
REQ-014 fd_soc in RX or DONE SHALL restart the frame per REQ-004; a flush takes priority over a same-cycle pop.
REQ-015 rx_enable falling in RX SHALL abort: flush the buffer, return to IDLE, no frame_done.
REQ-016 Status outputs (frame_len, frame_partial, crc_ok, frame_error) SHALL hold from DONE until the next fd_soc.
REQ-017 Read and write pointers SHALL wrap modulo BUFFER_DEPTH; full/empty SHALL use an extra pointer bit.

Reset
REQ-018 Reset SHALL force: FSM IDLE, buffer empty, out_valid 0, out_data 0, out_data_bits 0, frame_done 0, frame_len 0, frame_partial 0, crc_ok 0, frame_error 0, CRC register CRC_A_INIT.
REQ-019 Reset mid-frame SHALL discard all buffered data; no frame_done is produced.

Structure
REQ-020 CRC_A_INIT (16'h6363) and CRC_A_POLY (16'h8408) SHALL live in ISO14443A_pkg.
REQ-021 The byte-wide CRC update SHALL be a combinational sub-module crc_a (inputs: crc, byte; output: next crc), reusable by the transmit path.
REQ-022 The buffer SHALL be an inline register array; no separate FIFO module.

Verification
REQ-023 REQA: soc, one byte 0x26 with data_bits=7, eoc coincident -> frame_done, frame_len=1, frame_partial=1, crc_ok=0, out_data=0x26, out_data_bits=7.
REQ-024 HLTA: soc, bytes 0x50 0x00 0x57 0xCD, eoc -> frame_done, frame_len=4, crc_ok=1, frame_error=0; four bytes popped in order.
REQ-025 Same as REQ-024 with the last byte 0xCE -> crc_ok=0, frame_error=0.
REQ-026 BUFFER_DEPTH=16, 17 bytes, out_ready=0 -> 17th byte dropped, frame_error=1, frame_len=16, buffer holds bytes 1..16.
REQ-027 Mid-frame fd_parity_error, then eoc -> frame_error=1, crc_ok=0; rx_enable dropped mid-frame -> buffer empty next cycle, no frame_done.
REQ-028 out_ready held 1 while streaming bytes -> push and pop in the same cycle, occupancy stays 1, no byte lost; rst_n asserted mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/ISO14443A_pkg.sv
// Shared ISO/IEC 14443-A definitions: CRC_A constants, receive FSM states and buffer entry layout.
package ISO14443A_pkg;

   localparam logic [15:0] CRC_A_INIT = 16'h6363;
   localparam logic [15:0] CRC_A_POLY = 16'h8408;

   localparam int unsigned FRAME_LEN_W = 7;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned BITS_W      = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RX   = 2'd1,
      DONE = 2'd2
   } rx_state_e;

   // One buffered byte plus its valid-bit count (0 means all 8 bits)
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [BITS_W-1:0] bits;
   } rx_entry_t;

endpackage

// File: rtl/crc_a.sv
// Byte-wide CRC_A update (reflected poly 0x8408, LSB first); purely combinational.
module crc_a
   import ISO14443A_pkg::*;
(
   input  logic [15:0] crc,
   input  logic [7:0]  data,
   output logic [15:0] crc_next_c
);

   always_comb begin
      crc_next_c = crc ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         crc_next_c = crc_next_c[0] ? ((crc_next_c >> 1) ^ CRC_A_POLY) : (crc_next_c >> 1);
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: buffers decoded bytes, tracks frame status and checks the CRC_A residue.
module rx_frame_ctrl
   import ISO14443A_pkg::*;
#(
   parameter int unsigned BUFFER_DEPTH = 16
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rx_enable,
   input  logic        fd_soc,
   input  logic        fd_eoc,
   input  logic [7:0]  fd_data,
   input  logic [2:0]  fd_data_bits,
   input  logic        fd_data_valid,
   input  logic        fd_sequence_error,
   input  logic        fd_parity_error,
   output logic [7:0]  out_data,
   output logic [2:0]  out_data_bits,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_done,
   output logic [6:0]  frame_len,
   output logic        frame_partial,
   output logic        crc_ok,
   output logic        frame_error
);

   localparam int unsigned AW = $clog2(BUFFER_DEPTH);
   localparam int unsigned PW = AW + 1;

   rx_state_e state, state_n;

   logic [PW-1:0]          wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
   logic [15:0]            crc_q, crc_n, crc_upd;
   logic [FRAME_LEN_W-1:0] len_n;
   logic                   partial_n, err_n, crc_ok_n, frame_done_n, out_valid_n;
   logic [DATA_W-1:0]      out_data_n;
   logic [BITS_W-1:0]      out_bits_n;
   logic                   start, restart, flush_buf, push_ok, full;

   rx_entry_t mem [BUFFER_DEPTH];

   crc_a u_crc_a (
      .crc        (crc_q),
      .data       (fd_data),
      .crc_next_c (crc_upd)
   );

   // Extra pointer bit distinguishes full from empty
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign start = fd_soc && rx_enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         crc_q         <= CRC_A_INIT;
         frame_len     <= '0;
         frame_partial <= 1'b0;
         frame_error   <= 1'b0;
         crc_ok        <= 1'b0;
         frame_done    <= 1'b0;
         out_valid     <= 1'b0;
         out_data      <= '0;
         out_data_bits <= '0;
      end else begin
         state         <= state_n;
         wr_ptr        <= wr_ptr_n;
         rd_ptr        <= rd_ptr_n;
         crc_q         <= crc_n;
         frame_len     <= len_n;
         frame_partial <= partial_n;
         frame_error   <= err_n;
         crc_ok        <= crc_ok_n;
         frame_done    <= frame_done_n;
         out_valid     <= out_valid_n;
         out_data      <= out_data_n;
         out_data_bits <= out_bits_n;
      end
   end

   // Buffer storage carries no reset; reads are guarded by the pointers
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr[AW-1:0]] <= '{data: fd_data, bits: fd_data_bits};
      end
   end

   always_comb begin
      state_n      = state;
      wr_ptr_n     = wr_ptr;
      rd_ptr_n     = rd_ptr;
      crc_n        = crc_q;
      len_n        = frame_len;
      partial_n    = frame_partial;
      err_n        = frame_error;
      crc_ok_n     = crc_ok;
      restart      = 1'b0;
      flush_buf    = 1'b0;
      push_ok      = 1'b0;
      frame_done_n = 1'b0;
      out_valid_n  = 1'b0;
      out_data_n   = '0;
      out_bits_n   = '0;

      if (out_valid && out_ready) begin
         rd_ptr_n = rd_ptr + PW'(1);
      end

      unique case (state)
         IDLE: begin
            if (start) begin
               restart = 1'b1;
               state_n = RX;
            end
         end
         RX: begin
            if (!rx_enable) begin
               flush_buf = 1'b1;
               state_n   = IDLE;
            end else if (start) begin
               restart = 1'b1;
            end else begin
               if (fd_sequence_error || fd_parity_error) begin
                  err_n = 1'b1;
               end
               if (fd_data_valid) begin
                  if (full) begin
                     err_n = 1'b1;
                  end else begin
                     push_ok = 1'b1;
                  end
                  if (frame_len < FRAME_LEN_W'(BUFFER_DEPTH)) begin
                     len_n = frame_len + FRAME_LEN_W'(1);
                  end
                  partial_n = (fd_data_bits != '0);
                  if (fd_data_bits == '0) begin
                     crc_n = crc_upd;
                  end
               end
               // Final byte (possibly partial) is folded in before the verdict
               if (fd_eoc) begin
                  state_n  = DONE;
                  crc_ok_n = !partial_n && (len_n >= FRAME_LEN_W'(3)) && !err_n && (crc_n == 16'h0000);
               end
            end
         end
         DONE: begin
            if (start) begin
               restart = 1'b1;
               state_n = RX;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase

      if (restart) begin
         flush_buf = 1'b1;
         crc_n     = CRC_A_INIT;
         len_n     = '0;
         partial_n = 1'b0;
         err_n     = 1'b0;
         crc_ok_n  = 1'b0;
      end

      // Flush wins over a same-cycle pop
      if (flush_buf) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
      end else if (push_ok) begin
         wr_ptr_n = wr_ptr + PW'(1);
      end

      frame_done_n = (state_n == DONE);
      out_valid_n  = (wr_ptr_n != rd_ptr_n);

      // Head after this edge: the incoming byte if it lands in the head slot
      if (out_valid_n) begin
         if (push_ok && (rd_ptr_n[AW-1:0] == wr_ptr[AW-1:0])) begin
            out_data_n = fd_data;
            out_bits_n = fd_data_bits;
         end else begin
            out_data_n = mem[rd_ptr_n[AW-1:0]].data;
            out_bits_n = mem[rd_ptr_n[AW-1:0]].bits;
         end
      end
   end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: vector table, hand-written corner sequences and random traffic against a queue model.
module tb_rx_frame_ctrl;

   localparam int unsigned DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_enable, fd_soc, fd_eoc, fd_data_valid, fd_sequence_error, fd_parity_error, out_ready;
   logic [7:0] fd_data;
   logic [2:0] fd_data_bits;
   logic [7:0] out_data;
   logic [2:0] out_data_bits;
   logic       out_valid, frame_done, frame_partial, crc_ok, frame_error;
   logic [6:0] frame_len;

   typedef struct packed {
      logic       soc, eoc, dv;
      logic [7:0] data;
      logic [2:0] bits;
      logic       seq, par, en, rdy;
   } in_t;

   typedef struct packed {
      in_t        in;
      logic       done;
      logic [6:0] len;
      logic       part, cok, err, vld;
      logic [7:0] dat;
      logic [2:0] dbits;
   } vec_t;

   typedef struct packed {
      logic [7:0] d;
      logic [2:0] b;
   } ent_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   ent_t       m_q[$];
   logic [7:0] m_fb[$];
   int         m_mode = 0;
   int         m_len = 0;
   bit         m_part = 0, m_err = 0, m_cok = 0, m_done = 0;

   rx_frame_ctrl #(.BUFFER_DEPTH(DEPTH)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .rx_enable         (rx_enable),
      .fd_soc            (fd_soc),
      .fd_eoc            (fd_eoc),
      .fd_data           (fd_data),
      .fd_data_bits      (fd_data_bits),
      .fd_data_valid     (fd_data_valid),
      .fd_sequence_error (fd_sequence_error),
      .fd_parity_error   (fd_parity_error),
      .out_data          (out_data),
      .out_data_bits     (out_data_bits),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .frame_done        (frame_done),
      .frame_len         (frame_len),
      .frame_partial     (frame_partial),
      .crc_ok            (crc_ok),
      .frame_error       (frame_error)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic in_t mk(bit soc, bit eoc, bit dv, logic [7:0] d, logic [2:0] b, bit par, bit rdy);
      in_t v;
      v.soc = soc; v.eoc = eoc; v.dv = dv; v.data = d; v.bits = b;
      v.seq = 1'b0; v.par = par; v.en = 1'b1; v.rdy = rdy;
      return v;
   endfunction

   function automatic vec_t row(in_t v, bit done, int len, bit part, bit cok, bit err, bit vld,
                                logic [7:0] dat, logic [2:0] dbits);
      vec_t r;
      r.in = v; r.done = done; r.len = 7'(len); r.part = part; r.cok = cok; r.err = err;
      r.vld = vld; r.dat = dat; r.dbits = dbits;
      return r;
   endfunction

   // CRC_A residue over the full bytes of the frame, computed bit-serially
   function automatic logic [15:0] crc_of_frame();
      logic [15:0] c;
      bit          fbk;
      c = 16'h6363;
      foreach (m_fb[k]) begin
         for (int b = 0; b < 8; b++) begin
            fbk = c[0] ^ m_fb[k][b];
            c   = c >> 1;
            if (fbk) c = c ^ 16'h8408;
         end
      end
      return c;
   endfunction

   task automatic model_reset();
      m_q.delete(); m_fb.delete();
      m_mode = 0; m_len = 0; m_part = 0; m_err = 0; m_cok = 0; m_done = 0;
   endtask

   task automatic model_step(in_t v);
      bit   start, was_full, do_pop, flush, restart, push;
      ent_t e;
      start    = v.soc && v.en;
      was_full = (m_q.size() >= DEPTH);
      do_pop   = (m_q.size() > 0) && v.rdy;
      flush    = 0; restart = 0; push = 0;
      e.d = v.data; e.b = v.bits;
      m_done = 0;
      case (m_mode)
         0: if (start) restart = 1;
         1: begin
            if (!v.en) begin
               flush = 1; m_mode = 0;
            end else if (start) begin
               restart = 1;
            end else begin
               if (v.seq || v.par) m_err = 1;
               if (v.dv) begin
                  if (was_full) m_err = 1; else push = 1;
                  if (m_len < DEPTH) m_len++;
                  m_part = (v.bits != 0);
                  if (v.bits == 0) m_fb.push_back(v.data);
               end
               if (v.eoc) begin
                  m_mode = 2; m_done = 1;
                  m_cok  = !m_part && m_len >= 3 && !m_err && crc_of_frame() == 16'h0000;
               end
            end
         end
         default: if (start) restart = 1; else m_mode = 0;
      endcase
      if (restart) begin
         flush = 1; m_mode = 1; m_len = 0; m_part = 0; m_err = 0; m_cok = 0;
         m_fb.delete();
      end
      if (flush) begin
         m_q.delete();
      end else begin
         if (do_pop) m_q.delete(0);
         if (push) m_q.push_back(e);
      end
   endtask

   task automatic compare_model(string tag);
      chk({tag, ".frame_done"}, int'(frame_done), int'(m_done));
      chk({tag, ".frame_len"}, int'(frame_len), m_len);
      chk({tag, ".frame_partial"}, int'(frame_partial), int'(m_part));
      chk({tag, ".crc_ok"}, int'(crc_ok), int'(m_cok));
      chk({tag, ".frame_error"}, int'(frame_error), int'(m_err));
      chk({tag, ".out_valid"}, int'(out_valid), int'(m_q.size() > 0));
      chk({tag, ".out_data"}, int'(out_data), (m_q.size() > 0) ? int'(m_q[0].d) : 0);
      chk({tag, ".out_data_bits"}, int'(out_data_bits), (m_q.size() > 0) ? int'(m_q[0].b) : 0);
   endtask

   task automatic drive(in_t v);
      fd_soc = v.soc; fd_eoc = v.eoc; fd_data_valid = v.dv; fd_data = v.data;
      fd_data_bits = v.bits; fd_sequence_error = v.seq; fd_parity_error = v.par;
      rx_enable = v.en; out_ready = v.rdy;
   endtask

   task automatic cycle(in_t v, string tag);
      drive(v);
      model_step(v);
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   task automatic chk_all_zero(string tag);
      chk({tag, ".out_valid"}, int'(out_valid), 0);
      chk({tag, ".out_data"}, int'(out_data), 0);
      chk({tag, ".out_data_bits"}, int'(out_data_bits), 0);
      chk({tag, ".frame_done"}, int'(frame_done), 0);
      chk({tag, ".frame_len"}, int'(frame_len), 0);
      chk({tag, ".frame_partial"}, int'(frame_partial), 0);
      chk({tag, ".crc_ok"}, int'(crc_ok), 0);
      chk({tag, ".frame_error"}, int'(frame_error), 0);
   endtask

   vec_t tbl[22];
   in_t  idle, v;
   logic [7:0] hlta[4];

   initial begin
      idle = mk(0, 0, 0, 8'h00, 3'd0, 0, 0);
      hlta[0] = 8'h50; hlta[1] = 8'h00; hlta[2] = 8'h57; hlta[3] = 8'hCD;

      // REQA, HLTA with good CRC and pop-out, HLTA with bad CRC, parity error frame
      tbl[0]  = row(mk(1,0,0,8'h00,3'd0,0,0), 0,0,0,0,0, 0,8'h00,3'd0);
      tbl[1]  = row(mk(0,1,1,8'h26,3'd7,0,0), 1,1,1,0,0, 1,8'h26,3'd7);
      tbl[2]  = row(mk(0,0,0,8'h00,3'd0,0,1), 0,1,1,0,0, 0,8'h00,3'd0);
      tbl[3]  = row(mk(1,0,0,8'h00,3'd0,0,0), 0,0,0,0,0, 0,8'h00,3'd0);
      tbl[4]  = row(mk(0,0,1,8'h50,3'd0,0,0), 0,1,0,0,0, 1,8'h50,3'd0);
      tbl[5]  = row(mk(0,0,1,8'h00,3'd0,0,0), 0,2,0,0,0, 1,8'h50,3'd0);
      tbl[6]  = row(mk(0,0,1,8'h57,3'd0,0,0), 0,3,0,0,0, 1,8'h50,3'd0);
      tbl[7]  = row(mk(0,0,1,8'hCD,3'd0,0,0), 0,4,0,0,0, 1,8'h50,3'd0);
      tbl[8]  = row(mk(0,1,0,8'h00,3'd0,0,0), 1,4,0,1,0, 1,8'h50,3'd0);
      tbl[9]  = row(mk(0,0,0,8'h00,3'd0,0,1), 0,4,0,1,0, 1,8'h00,3'd0);
      tbl[10] = row(mk(0,0,0,8'h00,3'd0,0,1), 0,4,0,1,0, 1,8'h57,3'd0);
      tbl[11] = row(mk(0,0,0,8'h00,3'd0,0,1), 0,4,0,1,0, 1,8'hCD,3'd0);
      tbl[12] = row(mk(0,0,0,8'h00,3'd0,0,1), 0,4,0,1,0, 0,8'h00,3'd0);
      tbl[13] = row(mk(1,0,0,8'h00,3'd0,0,0), 0,0,0,0,0, 0,8'h00,3'd0);
      tbl[14] = row(mk(0,0,1,8'h50,3'd0,0,0), 0,1,0,0,0, 1,8'h50,3'd0);
      tbl[15] = row(mk(0,0,1,8'h00,3'd0,0,0), 0,2,0,0,0, 1,8'h50,3'd0);
      tbl[16] = row(mk(0,0,1,8'h57,3'd0,0,0), 0,3,0,0,0, 1,8'h50,3'd0);
      tbl[17] = row(mk(0,0,1,8'hCE,3'd0,0,0), 0,4,0,0,0, 1,8'h50,3'd0);
      tbl[18] = row(mk(0,1,0,8'h00,3'd0,0,0), 1,4,0,0,0, 1,8'h50,3'd0);
      tbl[19] = row(mk(1,0,0,8'h00,3'd0,0,1), 0,0,0,0,0, 0,8'h00,3'd0);
      tbl[20] = row(mk(0,0,1,8'h11,3'd0,1,0), 0,1,0,0,1, 1,8'h11,3'd0);
      tbl[21] = row(mk(0,1,0,8'h00,3'd0,0,0), 1,1,0,0,1, 1,8'h11,3'd0);

      rst_n = 1'b0;
      drive(idle);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         cycle(tbl[i].in, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d.done", i), int'(frame_done), int'(tbl[i].done));
         chk($sformatf("tbl%0d.len", i), int'(frame_len), int'(tbl[i].len));
         chk($sformatf("tbl%0d.partial", i), int'(frame_partial), int'(tbl[i].part));
         chk($sformatf("tbl%0d.crc_ok", i), int'(crc_ok), int'(tbl[i].cok));
         chk($sformatf("tbl%0d.err", i), int'(frame_error), int'(tbl[i].err));
         chk($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].vld));
         chk($sformatf("tbl%0d.data", i), int'(out_data), int'(tbl[i].dat));
         chk($sformatf("tbl%0d.bits", i), int'(out_data_bits), int'(tbl[i].dbits));
      end
      cycle(idle, "post_tbl");

      // Overflow: 17 bytes into a 16-deep buffer with no consumer
      cycle(mk(1,0,0,8'h00,3'd0,0,0), "ovf_soc");
      for (int i = 1; i <= 17; i++) cycle(mk(0,0,1,8'(i),3'd0,0,0), "ovf_push");
      cycle(mk(0,1,0,8'h00,3'd0,0,0), "ovf_eoc");
      chk("ovf.frame_len", int'(frame_len), 16);
      chk("ovf.frame_error", int'(frame_error), 1);
      chk("ovf.frame_done", int'(frame_done), 1);
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("ovf.head%0d", i), int'(out_data), i);
         cycle(mk(0,0,0,8'h00,3'd0,0,1), "ovf_pop");
      end
      chk("ovf.drained", int'(out_valid), 0);

      // Abort by dropping rx_enable mid-frame
      cycle(mk(1,0,0,8'h00,3'd0,0,0), "abort_soc");
      cycle(mk(0,0,1,8'hA5,3'd0,0,0), "abort_b0");
      cycle(mk(0,0,1,8'h5A,3'd0,0,0), "abort_b1");
      v = mk(0,1,0,8'h00,3'd0,0,0);
      v.en = 1'b0;
      cycle(v, "abort_drop");
      chk("abort.out_valid", int'(out_valid), 0);
      for (int i = 0; i < 3; i++) begin
         cycle(idle, "abort_idle");
         chk("abort.frame_done", int'(frame_done), 0);
      end

      // Streaming with out_ready held: occupancy stays at one
      cycle(mk(1,0,0,8'h00,3'd0,0,1), "stream_soc");
      for (int i = 0; i < 5; i++) begin
         cycle(mk(0,0,1,hlta[i % 4] ^ 8'(i),3'd0,0,1), "stream");
         chk($sformatf("stream%0d.valid", i), int'(out_valid), 1);
         chk($sformatf("stream%0d.data", i), int'(out_data), int'(hlta[i % 4] ^ 8'(i)));
      end
      cycle(mk(0,1,0,8'h00,3'd0,0,1), "stream_eoc");
      chk("stream.empty", int'(out_valid), 0);
      chk("stream.len", int'(frame_len), 5);

      // Asynchronous reset in the middle of a frame
      cycle(mk(1,0,0,8'h00,3'd0,0,0), "rst_soc");
      for (int i = 0; i < 3; i++) cycle(mk(0,0,1,8'hC0 + 8'(i),3'd0,0,0), "rst_push");
      rst_n = 1'b0;
      #2;
      chk_all_zero("midrst");
      model_reset();
      drive(idle);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cycle(idle, "post_rst");
         chk("post_rst.frame_done", int'(frame_done), 0);
      end

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         v.en   = ($urandom_range(0, 40) != 0);
         v.soc  = ($urandom_range(0, 30) == 0);
         v.eoc  = ($urandom_range(0, 20) == 0);
         v.dv   = ($urandom_range(0, 2) != 0);
         v.data = 8'($urandom);
         v.bits = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         v.seq  = ($urandom_range(0, 80) == 0);
         v.par  = ($urandom_range(0, 80) == 0);
         v.rdy  = ((i / 150) % 2 == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
         cycle(v, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
